audio_axil_regs: RTL
====================

AUDIO_AXIL_REGS -- requirements
Module: audio_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width.
REQ-003 SHALL have parameter SAMPLE_WIDTH, default 24, audio sample width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, exactly as decided below.
- S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID in, AWREADY out  (ADDR_WIDTH/3/1/1)  write address channel.
- S_AXI_WDATA/WSTRB/WVALID in, WREADY out  (32/4/1/1)  write data channel.
- S_AXI_BRESP/BVALID out, BREADY in  (2/1/1)  write response.
- S_AXI_ARADDR/ARPROT/ARVALID in, ARREADY out  (ADDR_WIDTH/3/1/1)  read address.
- S_AXI_RDATA/RRESP/RVALID out, RREADY in  (32/2/1/1)  read data.
- sample_valid  in  1  one-cycle strobe from audio receiver.
- sample_left, sample_right  in  SAMPLE_WIDTH each  two's-complement samples.
- irq  out  1  level, equals STATUS.NEW.

Function
REQ-005 SHALL decode byte address bits [4:2]: 0x00-0x0C REG0-REG3 RW; 0x10 LEFT RO; 0x14 RIGHT RO; 0x18 STATUS; 0x1C reads 0, writes ignored.
REQ-006 SHALL return RESP OKAY (2'b00) on every B and R response, including unmapped/RO addresses; AWPROT/ARPROT ignored.
REQ-007 SHALL accept AW and W independently: each READY high while its holding register is empty and BVALID low; latched beat held until its partner arrives.
REQ-008 SHALL perform the register write and assert BVALID the cycle after both AW and W are held (AW and W in same cycle -> BVALID next cycle).
REQ-009 SHALL apply WSTRB per byte lane to REG0-REG3; a zero strobe lane leaves that byte unchanged.
REQ-010 SHALL hold BVALID until BREADY; AWREADY/WREADY stay low while BVALID is high.
REQ-011 SHALL assert ARREADY when RVALID is low; RDATA/RVALID registered, valid the cycle after the AR handshake, held stable until RREADY.
REQ-012 SHALL return LEFT/RIGHT sign-extended from SAMPLE_WIDTH to 32 bits.
REQ-013 STATUS bit0 NEW: set on sample_valid, cleared by the AR handshake to 0x14; bit1 OVR: sticky, set when sample_valid arrives with NEW already 1, cleared by writing 1 to bit1 (WSTRB[0] set); bits 31:2 read 0.
REQ-014 SHALL latch sample_left/right together on sample_valid, overwriting previous values.
REQ-015 Simultaneous sample_valid and AR to 0x14: the read returns the old RIGHT; NEW stays 1; OVR not set.
REQ-016 Simultaneous OVR-clear write and overrun event: set wins.
REQ-017 Concurrent read and write to the same register: the read returns the pre-write value.

Reset
REQ-018 On S_AXI_ARESETN low, asynchronously: all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, REG0-REG3 0, LEFT/RIGHT 0, NEW 0, OVR 0, holding registers empty, irq 0.
REQ-019 Reset mid-transaction SHALL abandon it; no response is issued after reset release.

Structure
REQ-020 Register offsets, STATUS bit positions and RESP codes SHALL live in shared package audio_axil_pkg.
REQ-021 SHALL be a single module; no sub-module.

Verification
REQ-022 Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x00/0x04/0x08/0x0C, reading each back -> identical data, all responses OKAY.
REQ-023 W beat 3 cycles before AW to 0x04, then AW -> BVALID the cycle after AW; WSTRB=4'b0010 with data 0x0000AA00 over 0x11223344 -> reads 0x1122AA44.
REQ-024 sample_valid with left=0x800000, right=0x7FFFFF -> 0x10 reads 0xFF800000; 0x14 reads 0x007FFFFF; STATUS 0x1 before and 0x0 after the 0x14 read; irq follows.
REQ-025 Two sample_valid pulses without a read -> STATUS=0x3; write 0x2 to 0x18 -> STATUS=0x1.
REQ-026 BREADY/RREADY held low for 5 cycles -> BVALID/RVALID and RDATA stable; ARREADY stays low while RVALID is high; reset asserted mid-wait -> all valids 0 and REG0 = 0.

Source files
------------

// File: rtl/audio_axil_pkg.sv
// Register map, STATUS bit positions and response codes shared by the audio
// AXI-Lite register block and its users.
package audio_axil_pkg;

  localparam int unsigned REG_IDX_W   = 3;
  localparam int unsigned NUM_RW_REGS = 4;

  localparam logic [7:0] OFF_REG0   = 8'h00;
  localparam logic [7:0] OFF_REG1   = 8'h04;
  localparam logic [7:0] OFF_REG2   = 8'h08;
  localparam logic [7:0] OFF_REG3   = 8'h0C;
  localparam logic [7:0] OFF_LEFT   = 8'h10;
  localparam logic [7:0] OFF_RIGHT  = 8'h14;
  localparam logic [7:0] OFF_STATUS = 8'h18;
  localparam logic [7:0] OFF_RSVD   = 8'h1C;

  localparam int unsigned STATUS_NEW_BIT = 0;
  localparam int unsigned STATUS_OVR_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Word index taken from byte address bits [4:2]
  typedef enum logic [REG_IDX_W-1:0] {
    IDX_REG0   = OFF_REG0[4:2],
    IDX_REG1   = OFF_REG1[4:2],
    IDX_REG2   = OFF_REG2[4:2],
    IDX_REG3   = OFF_REG3[4:2],
    IDX_LEFT   = OFF_LEFT[4:2],
    IDX_RIGHT  = OFF_RIGHT[4:2],
    IDX_STATUS = OFF_STATUS[4:2],
    IDX_RSVD   = OFF_RSVD[4:2]
  } reg_idx_e;

endpackage

// File: rtl/audio_axil_regs.sv
// AXI4-Lite slave exposing four scratch registers, the latest stereo audio
// sample pair and a NEW/OVR status word that also drives the irq line.
module audio_axil_regs
  import audio_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned SAMPLE_WIDTH       = 24
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]         sample_left,
  input  logic [SAMPLE_WIDTH-1:0]         sample_right,
  output logic                            irq
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB = DW / 8;
  localparam int unsigned SW = SAMPLE_WIDTH;

  // Write holding registers and response state
  logic          aw_full_q, aw_full_d;
  reg_idx_e      aw_idx_q,  aw_idx_d;
  logic          w_full_q,  w_full_d;
  logic [DW-1:0] w_data_q,  w_data_d;
  logic [NB-1:0] w_strb_q,  w_strb_d;
  logic          awready_q, awready_d;
  logic          wready_q,  wready_d;
  logic          bvalid_q,  bvalid_d;

  // Read channel state
  logic          arready_q, arready_d;
  logic          rvalid_q,  rvalid_d;
  logic [DW-1:0] rdata_q,   rdata_d;

  // Register file, sample capture and status
  logic [DW-1:0] regs_q [NUM_RW_REGS];
  logic [DW-1:0] regs_d [NUM_RW_REGS];
  logic [SW-1:0] left_q,  left_d;
  logic [SW-1:0] right_q, right_d;
  logic          new_q,   new_d;
  logic          ovr_q,   ovr_d;

  logic          aw_hs, w_hs, ar_hs;
  logic          wr_fire, rd_right, ovr_clr;
  reg_idx_e      wr_idx, rd_idx;
  logic [DW-1:0] wr_data, rd_val, status_w;
  logic [NB-1:0] wr_strb;

  // Protection bits and address bits outside [4:2] carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    regs_d    = regs_q;
    left_d    = left_q;
    right_d   = right_q;
    new_d     = new_q;
    ovr_d     = ovr_q;

    aw_hs    = S_AXI_AWVALID & awready_q;
    w_hs     = S_AXI_WVALID & wready_q;
    ar_hs    = S_AXI_ARVALID & arready_q;

    // A beat arriving this cycle is used directly; a held one takes priority
    wr_idx   = aw_full_q ? aw_idx_q : reg_idx_e'(S_AXI_AWADDR[4:2]);
    wr_data  = w_full_q ? w_data_q : S_AXI_WDATA;
    wr_strb  = w_full_q ? w_strb_q : S_AXI_WSTRB;
    wr_fire  = (aw_full_q | aw_hs) & (w_full_q | w_hs);

    rd_idx   = reg_idx_e'(S_AXI_ARADDR[4:2]);
    rd_right = ar_hs & (rd_idx == IDX_RIGHT);
    ovr_clr  = wr_fire & (wr_idx == IDX_STATUS) & wr_strb[0] & wr_data[STATUS_OVR_BIT];

    status_w                 = '0;
    status_w[STATUS_NEW_BIT] = new_q;
    status_w[STATUS_OVR_BIT] = ovr_q;

    case (rd_idx)
      IDX_REG0, IDX_REG1,
      IDX_REG2, IDX_REG3: rd_val = regs_q[2'(rd_idx)];
      IDX_LEFT:           rd_val = {{(DW-SW){left_q[SW-1]}}, left_q};
      IDX_RIGHT:          rd_val = {{(DW-SW){right_q[SW-1]}}, right_q};
      IDX_STATUS:         rd_val = status_w;
      default:            rd_val = '0;
    endcase

    // Write path
    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (wr_fire) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_idx == IDX_REG0 || wr_idx == IDX_REG1 ||
          wr_idx == IDX_REG2 || wr_idx == IDX_REG3) begin
        for (int i = 0; i < int'(NB); i++) begin
          if (wr_strb[i]) begin
            regs_d[2'(wr_idx)][8*i +: 8] = wr_data[8*i +: 8];
          end
        end
      end
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_idx_d  = reg_idx_e'(S_AXI_AWADDR[4:2]);
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = S_AXI_WDATA;
        w_strb_d = S_AXI_WSTRB;
      end
    end

    // Read path; data reflects state before any same-cycle update
    if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
    end

    // Sample capture; a read of RIGHT in the same cycle consumes the old pair
    if (sample_valid) begin
      left_d  = sample_left;
      right_d = sample_right;
    end
    if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    if (sample_valid && new_q && !rd_right) begin
      ovr_d = 1'b1;
    end
    if (rd_right) begin
      new_d = 1'b0;
    end
    if (sample_valid) begin
      new_d = 1'b1;
    end

    awready_d = ~aw_full_d & ~bvalid_d;
    wready_d  = ~w_full_d & ~bvalid_d;
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= IDX_REG0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      regs_q    <= '{default: '0};
      left_q    <= '0;
      right_q   <= '0;
      new_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
      left_q    <= left_d;
      right_q   <= right_d;
      new_q     <= new_d;
      ovr_q     <= ovr_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign irq           = new_q;

endmodule
